hyperram_frame_reader: RTL and testbench

- Read-side DMA engine for the HyperRAM frame buffer.
- On a start pulse, issues sequential 128-bit Read Memory requests (iOpReq=3'b011) to the W958D6NBKX HyperRAM core and pushes each returned word into a downstream dual-clock FIFO.
- Complements the frame-write path: it drains a stored frame toward the UART or host uplink, or toward any other 128-bit consumer.

---
 rtl/hyperram_frame_reader.sv | 129 ++++++++++++
 tb/tb_hyperram_frame_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_frame_reader.sv
// Read-side frame DMA: streams nBeats 128-bit HyperRAM reads into a FIFO, one read outstanding, FIFO-full stalls PUSH.
// Optional HYPERRAM_RD_CHECKSUM_EN adds oChecksum (mod-2^32 sum of 32-bit lanes of every word written).
module hyperram_frame_reader #(
  parameter int ADDR_W     = 23,
  parameter int ADDR_STEP  = 8,
  parameter int BEAT_CNT_W = 28
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iEn,
  input  logic                  iStart,
  input  logic [ADDR_W-1:0]     iBaseAddr,
  input  logic [31:0]           iFrmBytes,
  output logic                  oEn,
  output logic [2:0]            oOpReq,
  output logic [ADDR_W-1:0]     oOpMemAddr,
  input  logic [127:0]          iRdData,
  input  logic                  iOpDone,
  output logic                  oWrEnFIFO,
  output logic [127:0]          oWrDataFIFO,
  input  logic                  iFullFIFO,
  output logic                  oBusy,
  output logic                  oFrmDone,
  output logic [BEAT_CNT_W-1:0] oBeatCnt
`ifdef HYPERRAM_RD_CHECKSUM_EN
  ,
  output logic [31:0]           oChecksum
`endif
);

  // One extra bit: a 4 GiB frame needs 2^28 beats.
  localparam int NB_W = BEAT_CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state;
  state_t                stateNxt;
  logic [ADDR_W-1:0]     addr;
  logic [NB_W-1:0]       nBeats;
  logic [NB_W-1:0]       nBeatsCalc;
  logic [BEAT_CNT_W-1:0] beatCnt;
  logic [NB_W-1:0]       beatCntInc;
  logic [127:0]          holdDat;
  logic                  startAcc;
  logic                  pushFire;

  assign nBeatsCalc = NB_W'(({1'b0, iFrmBytes} + 33'd15) >> 4);
  assign beatCntInc = {1'b0, beatCnt} + NB_W'(1);
  assign startAcc   = iEn && (state == IDLE) && iStart;
  assign pushFire   = iEn && (state == PUSH) && !iFullFIFO;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (iStart) stateNxt = CHECK;
      CHECK:   stateNxt = (nBeats == '0) ? DONE : REQ;
      REQ:     stateNxt = WAIT;
      WAIT:    if (iOpDone) stateNxt = PUSH;
      PUSH:    if (!iFullFIFO) stateNxt = (beatCntInc == nBeats) ? DONE : REQ;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
    end else if (iEn) begin
      state <= stateNxt;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      addr    <= '0;
      nBeats  <= '0;
      beatCnt <= '0;
      holdDat <= '0;
    end else begin
      if (startAcc) begin
        addr    <= iBaseAddr;
        nBeats  <= nBeatsCalc;
        beatCnt <= '0;
      end
      if (iEn && (state == WAIT) && iOpDone) begin
        holdDat <= iRdData;
      end
      // Address wraps naturally at 2^ADDR_W.
      if (pushFire) begin
        beatCnt <= beatCnt + BEAT_CNT_W'(1);
        addr    <= addr + ADDR_W'(ADDR_STEP);
      end
    end
  end

`ifdef HYPERRAM_RD_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      csum <= '0;
    end else if (startAcc) begin
      csum <= '0;
    end else if (pushFire) begin
      csum <= csum + holdDat[31:0] + holdDat[63:32] + holdDat[95:64] + holdDat[127:96];
    end
  end

  assign oChecksum = csum;
`endif

  // oEn decodes from state so it stays put while iEn is low.
  assign oEn         = (state == REQ) || (state == WAIT);
  assign oOpReq      = 3'b011;
  assign oOpMemAddr  = addr;
  assign oWrEnFIFO   = pushFire;
  assign oWrDataFIFO = holdDat;
  assign oBusy       = (state != IDLE);
  assign oFrmDone    = iEn && (state == DONE);
  assign oBeatCnt    = beatCnt;

endmodule

// File: tb/tb_hyperram_frame_reader.sv
// Randomized bench for hyperram_frame_reader with a behavioural HyperRAM core and FIFO scoreboard.
module tb_hyperram_frame_reader;
  localparam int ADDR_W = 23;
  localparam int BCW    = 28;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic              iEn;
  logic              iStart;
  logic [ADDR_W-1:0] iBaseAddr;
  logic [31:0]       iFrmBytes;
  logic              oEn;
  logic [2:0]        oOpReq;
  logic [ADDR_W-1:0] oOpMemAddr;
  logic [127:0]      iRdData;
  logic              iOpDone;
  logic              oWrEnFIFO;
  logic [127:0]      oWrDataFIFO;
  logic              iFullFIFO;
  logic              oBusy;
  logic              oFrmDone;
  logic [BCW-1:0]    oBeatCnt;
`ifdef HYPERRAM_RD_CHECKSUM_EN
  logic [31:0]       oChecksum;
`endif

  always #5 iClk = ~iClk;

  hyperram_frame_reader dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iStart(iStart),
    .iBaseAddr(iBaseAddr), .iFrmBytes(iFrmBytes),
    .oEn(oEn), .oOpReq(oOpReq), .oOpMemAddr(oOpMemAddr),
    .iRdData(iRdData), .iOpDone(iOpDone),
    .oWrEnFIFO(oWrEnFIFO), .oWrDataFIFO(oWrDataFIFO), .iFullFIFO(iFullFIFO),
    .oBusy(oBusy), .oFrmDone(oFrmDone), .oBeatCnt(oBeatCnt)
`ifdef HYPERRAM_RD_CHECKSUM_EN
    , .oChecksum(oChecksum)
`endif
  );

  int errCnt = 0;
  int chkCnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: the word returned for an address is a fixed function of it and a per-frame salt.
  int          coreLat  = 10;
  int          coreCnt  = 0;
  logic [31:0] salt     = 32'h0;
  bit          spurDone = 1'b0;

  function automatic logic [127:0] wordOf(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    logic [31:0] a32;
    a32 = 32'(a);
    return {s ^ a32, a32 * 32'h9E3779B9, s + a32, a32};
  endfunction

  initial begin
    iOpDone = 1'b0;
    iRdData = '0;
    forever begin
      @(negedge iClk);
      iOpDone = 1'b0;
      if (spurDone) begin
        iOpDone  = 1'b1;
        iRdData  = wordOf(23'h5A5A5, ~salt);
        spurDone = 1'b0;
      end else if (oEn && iRstN) begin
        if (iEn) begin
          coreCnt++;
          if (coreCnt >= coreLat) begin
            iOpDone = 1'b1;
            iRdData = wordOf(oOpMemAddr, salt);
            coreCnt = 0;
          end
        end
      end else begin
        coreCnt = 0;
      end
    end
  end

  // Monitor: records new requests, FIFO writes and done pulses.
  logic [ADDR_W-1:0] reqQ[$];
  logic [127:0]      wrQ[$];
  int                doneCnt = 0;
  logic              prevEn  = 1'b0;

  initial begin
    forever begin
      @(negedge iClk);
      #1;
      if (oEn && !prevEn) begin
        reqQ.push_back(oOpMemAddr);
        check("opreq", oOpReq, 3'b011);
      end
      prevEn = oEn;
      if (oWrEnFIFO) begin
        check("beatcnt_pre", oBeatCnt, wrQ.size());
        wrQ.push_back(oWrDataFIFO);
      end
      if (oFrmDone) doneCnt++;
    end
  end

  task automatic runFrame(input logic [ADDR_W-1:0] base, input logic [31:0] bytes,
                          input bit randFull, input bit restart, input bit fullHold, input bit enStall);
    int                nb;
    int                seen;
    int                fullCyc;
    bit                holding;
    bit                stalled;
    logic [31:0]       csum;
    logic [ADDR_W-1:0] a;
    logic [127:0]      w;
    nb      = int'((64'(bytes) + 64'd15) / 64'd16);
    seen    = 0;
    fullCyc = 0;
    holding = fullHold;
    stalled = 1'b0;
    reqQ.delete();
    wrQ.delete();
    doneCnt   = 0;
    salt      = $urandom;
    iFullFIFO = fullHold;
    iBaseAddr = base;
    iFrmBytes = bytes;
    iStart    = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge iClk);
      iStart = 1'b0;
      if (cyc == 1) check("busy_after_start", oBusy, 1'b1);
      if (restart && cyc == 15) begin
        iBaseAddr = base ^ 23'h1234;
        iFrmBytes = 32'd999;
        iStart    = 1'b1;
      end
      if (randFull) iFullFIFO = ($urandom_range(0, 2) == 0);
      if (holding && reqQ.size() >= 1 && !oEn) begin
        fullCyc++;
        if (fullCyc == 20) begin
          check("full_no_write", wrQ.size(), 0);
          check("full_no_second_req", reqQ.size(), 1);
          iFullFIFO = 1'b0;
          holding   = 1'b0;
        end
      end
      if (enStall && !stalled && reqQ.size() == 1 && oEn) begin
        stalled = 1'b1;
        iEn     = 1'b0;
        repeat (5) begin
          @(negedge iClk);
          check("stall_oen_held", oEn, 1'b1);
          check("stall_addr_held", oOpMemAddr, base);
          check("stall_no_write", oWrEnFIFO, 1'b0);
          check("stall_busy_held", oBusy, 1'b1);
        end
        iEn = 1'b1;
      end
      if (oFrmDone) begin
        seen = cyc;
        break;
      end
    end
    iFullFIFO = 1'b0;
    check("frame_done_seen", seen != 0, 1'b1);
    if (bytes == 0) check("zero_done_latency", seen, 2);
    @(negedge iClk);
    check("done_pulse_width", oFrmDone, 1'b0);
    check("busy_after_done", oBusy, 1'b0);
    #2;
    check("done_count", doneCnt, 1);
    check("req_count", reqQ.size(), nb);
    check("wr_count", wrQ.size(), nb);
    check("beatcnt_final", oBeatCnt, nb);
    csum = 32'h0;
    for (int i = 0; i < nb; i++) begin
      a = ADDR_W'((64'(base) + 64'(8 * i)) & ((64'd1 << ADDR_W) - 64'd1));
      w = wordOf(a, salt);
      if (i < reqQ.size()) check("req_addr", reqQ[i], a);
      if (i < wrQ.size()) check("wr_data", wrQ[i], w);
      csum = csum + w[31:0] + w[63:32] + w[95:64] + w[127:96];
    end
`ifdef HYPERRAM_RD_CHECKSUM_EN
    check("checksum", oChecksum, csum);
`endif
  endtask

  task automatic resetMidFrame();
    reqQ.delete();
    wrQ.delete();
    doneCnt   = 0;
    iBaseAddr = 23'h100;
    iFrmBytes = 32'd64;
    iStart    = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 0; i < 50 && reqQ.size() == 0; i++) @(negedge iClk);
    repeat (2) @(negedge iClk);
    check("rst_pre_oen", oEn, 1'b1);
    iRstN = 1'b0;
    #1;
    check("rst_oen", oEn, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_beatcnt", oBeatCnt, 0);
    @(negedge iClk);
    iRstN = 1'b1;
    #2;
    doneCnt = 0;
    reqQ.delete();
    wrQ.delete();
    repeat (20) @(negedge iClk);
    #2;
    check("rst_no_done", doneCnt, 0);
    check("rst_no_req", reqQ.size(), 0);
    check("rst_no_write", wrQ.size(), 0);
  endtask

  initial begin
    iRstN     = 1'b0;
    iEn       = 1'b1;
    iStart    = 1'b0;
    iBaseAddr = '0;
    iFrmBytes = '0;
    iFullFIFO = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst_oen0", oEn, 1'b0);
    check("rst_opreq", oOpReq, 3'b011);
    check("rst_addr", oOpMemAddr, 0);
    check("rst_wren", oWrEnFIFO, 1'b0);
    check("rst_wrdata", oWrDataFIFO, 0);
    check("rst_busy0", oBusy, 1'b0);
    check("rst_done0", oFrmDone, 1'b0);
    check("rst_beatcnt0", oBeatCnt, 0);
    iRstN = 1'b1;
    @(negedge iClk);
    check("post_rst_oen", oEn, 1'b0);
    check("post_rst_wren", oWrEnFIFO, 1'b0);

    coreLat = 10;
    runFrame(23'h0, 32'd48, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(23'h0, 32'd17, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(23'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(23'h0, 32'd48, 1'b0, 1'b0, 1'b1, 1'b0);
    runFrame(23'h7FFFF8, 32'd32, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(23'h40, 32'd128, 1'b0, 1'b1, 1'b0, 1'b0);
    runFrame(23'h200, 32'd32, 1'b0, 1'b0, 1'b0, 1'b1);
    resetMidFrame();

    spurDone = 1'b1;
    repeat (5) @(negedge iClk);
    #2;
    check("spur_no_write", wrQ.size(), 0);
    check("spur_idle", oBusy, 1'b0);
    check("spur_no_req", oEn, 1'b0);

    for (int k = 0; k < 8; k++) begin
      coreLat = $urandom_range(2, 12);
      runFrame(ADDR_W'($urandom), 32'($urandom_range(0, 120)), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
